// File: rtl/f2x_pkg.sv
// Shared definitions for the IEEE-754 single to signed fixed-point converter.
package f2x_pkg;

    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned WORD_W   = SIGN_W + EXP_W + MAN_W;
    localparam int unsigned SIG_W    = MAN_W + 1;
    localparam int unsigned EXP_BIAS = 127;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } f2x_cls_e;

    typedef struct packed {
        logic ovf;
        logic nan;
        logic inexact;
    } f2x_flags_t;

    function automatic f2x_cls_e f2x_classify(input logic [EXP_W-1:0] e_fld,
                                              input logic [MAN_W-1:0] m_fld);
        if (e_fld == '0) return (m_fld == '0) ? CLS_ZERO : CLS_DENORM;
        if (e_fld == '1) return (m_fld == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/float_to_fixed_pipe_if.sv
// Operand/result valid-ready bus of the float-to-fixed converter.
interface float_to_fixed_pipe_if
    import f2x_pkg::*;
#(
    parameter int unsigned OUT_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_ovf;
    logic              out_nan;
    logic              out_inexact;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
    );
endinterface

// File: rtl/f2x_shift.sv
// Barrel shifter for the significand: left shift, or right shift with guard/sticky.
module f2x_shift #(
    parameter int unsigned SIG_W = 24,
    parameter int unsigned MAG_W = 48,
    parameter int unsigned AMT_W = 6
) (
    input  logic [SIG_W-1:0] i_mant,
    input  logic             i_left,
    input  logic [AMT_W-1:0] i_amt,
    output logic [MAG_W-1:0] o_mag_c,
    output logic             o_guard_c,
    output logic             o_sticky_c
);
    // Two spare low bits keep the LSB visible to sticky at the largest right shift.
    localparam int unsigned EXT_W = 2 * SIG_W + 2;

    logic [EXT_W-1:0] w_ext;

    always_comb begin
        w_ext      = {i_mant, (SIG_W + 2)'(0)} >> i_amt;
        o_mag_c    = '0;
        o_guard_c  = 1'b0;
        o_sticky_c = 1'b0;
        if (i_left) begin
            o_mag_c = MAG_W'(i_mant) << i_amt;
        end else begin
            o_mag_c    = MAG_W'(w_ext[EXT_W-1 -: SIG_W]);
            o_guard_c  = w_ext[SIG_W+1];
            o_sticky_c = |w_ext[SIG_W:0];
        end
    end
endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with global stall.
// Define F2X_ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module float_to_fixed_pipe
    import f2x_pkg::*;
#(
    parameter int unsigned OUT_W  = 24,
    parameter int unsigned FRAC_W = 0
) (
    input logic             clk,
    input logic             rst,
    float_to_fixed_pipe_if.slave bus
);
    localparam int unsigned MAG_W   = OUT_W + SIG_W;
    localparam int unsigned AMT_W   = 6;
    localparam int          RSH_MAX = int'(SIG_W) + 1;
    localparam logic [MAG_W:0] NEG_LIM = (MAG_W + 1)'(1) << (OUT_W - 1);
    localparam logic [MAG_W:0] POS_LIM = NEG_LIM - (MAG_W + 1)'(1);

    logic w_advance;

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_frac;
    f2x_cls_e         w_cls;
    int               w_sh;
    logic             w_left;
    logic             w_ovf_pre;
    logic [AMT_W-1:0] w_amt;

    logic             r_s1_valid, r_s1_sign, r_s1_left, r_s1_ovf_pre;
    f2x_cls_e         r_s1_cls;
    logic [AMT_W-1:0] r_s1_amt;
    logic [SIG_W-1:0] r_s1_mant;

    logic [MAG_W-1:0] w_mag;
    logic             w_guard, w_sticky;

    logic             r_s2_valid, r_s2_sign, r_s2_ovf_pre, r_s2_guard, r_s2_sticky;
    f2x_cls_e         r_s2_cls;
    logic [MAG_W-1:0] r_s2_mag;

    logic             w_inc;
    logic [MAG_W:0]   w_rmag;
    logic [OUT_W-1:0] w_sat, w_data;
    f2x_flags_t       w_flags;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    f2x_flags_t       r_flags;

    assign w_advance       = ~r_out_valid | bus.out_ready;
    assign bus.in_ready    = w_advance;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_ovf     = r_flags.ovf;
    assign bus.out_nan     = r_flags.nan;
    assign bus.out_inexact = r_flags.inexact;

    // S1: classify and turn the unbiased exponent into a shift direction/amount.
    always_comb begin
        w_exp     = bus.in_data[MAN_W +: EXP_W];
        w_frac    = bus.in_data[MAN_W-1:0];
        w_cls     = f2x_classify(w_exp, w_frac);
        w_sh      = int'(w_exp) - int'(EXP_BIAS) - int'(MAN_W) + int'(FRAC_W);
        w_left    = 1'b0;
        w_ovf_pre = 1'b0;
        w_amt     = '0;
        if (w_sh >= 0) begin
            w_left = 1'b1;
            if (w_sh >= int'(OUT_W)) w_ovf_pre = 1'b1;
            else                     w_amt     = AMT_W'(w_sh);
        end else if (w_sh < -RSH_MAX) begin
            w_amt = AMT_W'(RSH_MAX);
        end else begin
            w_amt = AMT_W'(-w_sh);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_left    <= 1'b0;
            r_s1_ovf_pre <= 1'b0;
            r_s1_cls     <= CLS_ZERO;
            r_s1_amt     <= '0;
            r_s1_mant    <= '0;
        end else if (w_advance) begin
            r_s1_valid   <= bus.in_valid;
            r_s1_sign    <= bus.in_data[WORD_W-1];
            r_s1_left    <= w_left;
            r_s1_ovf_pre <= w_ovf_pre;
            r_s1_cls     <= w_cls;
            r_s1_amt     <= w_amt;
            r_s1_mant    <= {1'b1, w_frac};
        end
    end

    f2x_shift #(
        .SIG_W (SIG_W),
        .MAG_W (MAG_W),
        .AMT_W (AMT_W)
    ) u_shift (
        .i_mant     (r_s1_mant),
        .i_left     (r_s1_left),
        .i_amt      (r_s1_amt),
        .o_mag_c    (w_mag),
        .o_guard_c  (w_guard),
        .o_sticky_c (w_sticky)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_ovf_pre <= 1'b0;
            r_s2_guard   <= 1'b0;
            r_s2_sticky  <= 1'b0;
            r_s2_cls     <= CLS_ZERO;
            r_s2_mag     <= '0;
        end else if (w_advance) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_sign    <= r_s1_sign;
            r_s2_ovf_pre <= r_s1_ovf_pre;
            r_s2_guard   <= w_guard;
            r_s2_sticky  <= w_sticky;
            r_s2_cls     <= r_s1_cls;
            r_s2_mag     <= w_mag;
        end
    end

    // S3: round the magnitude, then range-check (a rounding carry can overflow), then negate.
    always_comb begin
`ifdef F2X_ROUND_NEAREST_EN
        w_inc = r_s2_guard & (r_s2_sticky | r_s2_mag[0]);
`else
        w_inc = 1'b0;
`endif
        w_rmag  = (MAG_W + 1)'(r_s2_mag) + (MAG_W + 1)'(w_inc);
        w_sat   = r_s2_sign ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
        w_data  = '0;
        w_flags = '0;
        case (r_s2_cls)
            CLS_DENORM: w_flags.inexact = 1'b1;
            CLS_NAN:    w_flags.nan     = 1'b1;
            CLS_INF: begin
                w_data      = w_sat;
                w_flags.ovf = 1'b1;
            end
            CLS_NORMAL: begin
                if (r_s2_ovf_pre || (w_rmag > (r_s2_sign ? NEG_LIM : POS_LIM))) begin
                    w_data      = w_sat;
                    w_flags.ovf = 1'b1;
                end else begin
                    w_data          = OUT_W'(r_s2_sign ? -w_rmag : w_rmag);
                    w_flags.inexact = r_s2_guard | r_s2_sticky;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_flags     <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            r_out_data  <= w_data;
            r_flags     <= w_flags;
        end
    end
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed bench for float_to_fixed_pipe: OUT_W=24 with FRAC_W=0 and FRAC_W=8 instances.
module tb_float_to_fixed_pipe;
`ifdef F2X_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_to_fixed_pipe_if #(.OUT_W(24)) bus0 ();
    float_to_fixed_pipe_if #(.OUT_W(24)) bus8 ();

    float_to_fixed_pipe #(.OUT_W(24), .FRAC_W(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    float_to_fixed_pipe #(.OUT_W(24), .FRAC_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_run  = 0;
    int n_fail = 0;

    // {input, expected data, expected {ovf,nan,inexact}} for the FRAC_W=0 instance
    logic [31:0] v_in  [0:11] = '{32'h40490FDB, 32'h3FC00000, 32'h40200000, 32'hC0200000,
                                  32'h3F800000, 32'h4B800000, 32'hCB000000, 32'hFF800000,
                                  32'h7FC00000, 32'h00000001, 32'h80000000, 32'h4AFFFFFF};
    logic [31:0] v_dat [0:11] = '{32'h000003, (RNE ? 32'h000002 : 32'h000001), 32'h000002,
                                  32'hFFFFFE, 32'h000001, 32'h7FFFFF, 32'h800000, 32'h800000,
                                  32'h000000, 32'h000000, 32'h000000, 32'h7FFFFF};
    logic [31:0] v_flg [0:11] = '{32'b001, 32'b001, 32'b001, 32'b001, 32'b000, 32'b100,
                                  32'b000, 32'b100, 32'b010, 32'b001, 32'b000,
                                  (RNE ? 32'b100 : 32'b001)};

    logic [31:0] f8_in  [0:2] = '{32'hBF400000, 32'h3B800000, 32'h40490FDB};
    logic [31:0] f8_dat [0:2] = '{32'hFFFF40, 32'h000001, 32'h000324};
    logic [31:0] f8_flg [0:2] = '{32'b000, 32'b000, 32'b001};

    logic [31:0] st_in [0:7] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
        bus0.in_valid = v; bus0.in_data = d; bus0.out_ready = rdy;
        bus8.in_valid = v; bus8.in_data = d; bus8.out_ready = rdy;
    endtask

    // Offer one operand, return out_valid one cycle before the expected result.
    task automatic push(input logic [31:0] d, output logic early);
        @(negedge clk); drive(1'b1, d, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, 1'b1);
        @(negedge clk); early = bus0.out_valid;
        @(negedge clk);
    endtask

    function automatic logic [31:0] flags0();
        return {29'h0, bus0.out_ovf, bus0.out_nan, bus0.out_inexact};
    endfunction

    function automatic logic [31:0] flags8();
        return {29'h0, bus8.out_ovf, bus8.out_nan, bus8.out_inexact};
    endfunction

    initial begin
        logic        early;
        int          sent, recv, ghost;
        bit          seen_low, prev_stall;
        logic [31:0] prev_data;

        drive(1'b1, 32'h3F800000, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        check_eq("rst_out_valid", 32'(bus0.out_valid), 32'h0);
        check_eq("rst_out_data",  32'(bus0.out_data),  32'h0);
        check_eq("rst_flags",     flags0(),            32'h0);
        check_eq("rst_in_ready",  32'(bus0.in_ready),  32'h1);

        for (int i = 0; i < 12; i++) begin
            push(v_in[i], early);
            check_eq($sformatf("v%0d_early", i), 32'(early), 32'h0);
            check_eq($sformatf("v%0d_valid", i), 32'(bus0.out_valid), 32'h1);
            check_eq($sformatf("v%0d_data", i),  32'(bus0.out_data), v_dat[i]);
            check_eq($sformatf("v%0d_flags", i), flags0(), v_flg[i]);
        end

        for (int j = 0; j < 3; j++) begin
            push(f8_in[j], early);
            check_eq($sformatf("f8_%0d_valid", j), 32'(bus8.out_valid), 32'h1);
            check_eq($sformatf("f8_%0d_data", j),  32'(bus8.out_data), f8_dat[j]);
            check_eq($sformatf("f8_%0d_flags", j), flags8(), f8_flg[j]);
        end

        // Back-to-back stream with out_ready low in cycles 2..6
        sent = 0; recv = 0; seen_low = 1'b0; prev_stall = 1'b0; prev_data = 32'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            drive(sent < 8, (sent < 8) ? st_in[sent % 8] : 32'h0, !(c >= 2 && c <= 6));
            #1;
            if (!bus0.in_ready) seen_low = 1'b1;
            if (prev_stall) begin
                check_eq($sformatf("hold_valid_c%0d", c), 32'(bus0.out_valid), 32'h1);
                check_eq($sformatf("hold_data_c%0d", c),  32'(bus0.out_data), prev_data);
            end
            if (bus0.out_valid && bus0.out_ready) begin
                check_eq($sformatf("stream_%0d", recv), 32'(bus0.out_data), 32'(recv + 1));
                recv++;
            end
            prev_stall = bus0.out_valid && !bus0.out_ready;
            prev_data  = 32'(bus0.out_data);
            if (bus0.in_valid && bus0.in_ready) sent++;
        end
        check_eq("stream_in_ready_low", 32'(seen_low), 32'h1);
        check_eq("stream_count", 32'(recv), 32'd8);

        // Reset with three operands in flight and a fourth offered during reset
        @(negedge clk); drive(1'b1, 32'h3F800000, 1'b1);
        @(negedge clk); drive(1'b1, 32'h40000000, 1'b1);
        @(negedge clk); drive(1'b1, 32'h40400000, 1'b1);
        @(negedge clk); drive(1'b1, 32'h40800000, 1'b1); rst = 1'b1;
        @(negedge clk); rst = 1'b0; drive(1'b0, 32'h0, 1'b1);
        check_eq("midrst_out_valid", 32'(bus0.out_valid), 32'h0);
        check_eq("midrst_out_data",  32'(bus0.out_data),  32'h0);
        check_eq("midrst_flags",     flags0(),            32'h0);
        check_eq("midrst_in_ready",  32'(bus0.in_ready),  32'h1);
        ghost = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus0.out_valid) ghost++;
        end
        check_eq("midrst_ghosts", 32'(ghost), 32'h0);

        push(32'h40A00000, early);
        check_eq("post_rst_data", 32'(bus0.out_data), 32'h000005);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/float_to_fixed_pipe.md
FLOAT_TO_FIXED_PIPE -- requirements
Module: float_to_fixed_pipe

Interface
REQ-001 SHALL provide parameter OUT_W, default 24, total signed two's-complement output width, legal range 8..32.
REQ-002 SHALL provide parameter FRAC_W, default 0, number of fractional output bits, legal range 0..OUT_W-1.
REQ-003 SHALL use one clock, clk, and a synchronous active-high reset, rst; all state changes on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_data holds a valid IEEE-754 single.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  32  IEEE-754 single-precision operand.
REQ-009 out_valid  output  1  out_data and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_data  output  OUT_W  signed fixed-point result, FRAC_W fractional bits.
REQ-012 out_ovf, out_nan, out_inexact  output  1 each  saturation, NaN input, precision lost.

Function
REQ-013 SHALL compute round(value * 2^FRAC_W), where value = (-1)^s * 1.m * 2^(e-127); rounding mode per REQ-025.
REQ-014 SHALL implement three stages: S1 unpack/classify, S2 magnitude right/left shift with guard and sticky bits, S3 round, saturate, negate.
REQ-015 SHALL use a global stall: advance = ~out_valid | out_ready; in_ready = advance; a transfer occurs only when valid and ready are both high.
REQ-016 SHALL produce each result exactly 3 cycles after acceptance when out_ready is held high; throughput one result per cycle.
REQ-017 SHALL hold out_data and all flags stable while out_valid=1 and out_ready=0.
REQ-018 SHALL never drop, duplicate or reorder results under any out_ready pattern.
REQ-019 SHALL, for zero input (either sign), return 0 with all flags 0.
REQ-020 SHALL flush denormal inputs to 0, with out_inexact=1.
REQ-021 SHALL, for NaN, return 0 with out_nan=1 and the other flags 0.
REQ-022 SHALL, for +/-infinity or any rounded magnitude beyond range, saturate to 2^(OUT_W-1)-1 or -2^(OUT_W-1) with out_ovf=1; -2^(OUT_W-1) exactly is not an overflow.
REQ-023 SHALL set out_inexact=1 whenever any nonzero bit is discarded by shift or rounding, and 0 when out_ovf or out_nan is set.
REQ-024 SHALL evaluate the overflow check after rounding; a round-up carry into the sign position saturates.

Configuration
REQ-025 SHALL compile round-to-nearest-even on the magnitude (ties to even, then negated) when macro F2X_ROUND_NEAREST_EN is defined; SHALL truncate toward zero otherwise; S3 latency is identical in both builds.

Reset
REQ-026 SHALL, on rst=1, clear all stage valids next edge: out_valid=0, out_data=0, all flags 0, in_ready=1 the cycle after reset.
REQ-027 SHALL discard in-flight operands on reset mid-operation; no result from before reset appears afterward.
REQ-028 SHALL ignore in_valid during the reset cycle.

Structure
REQ-029 SHALL place in shared package f2x_pkg: exponent bias 127, field widths (1/8/23), operand class enum (ZERO, DENORM, NORMAL, INF, NAN), flag-bundle typedef.
REQ-030 SHALL implement the S2 shift in sub-module f2x_shift (parametrised barrel shifter returning shifted magnitude, guard bit, sticky bit).
REQ-031 SHALL keep the top-level to the handshake, pipeline registers and S1/S3 logic.

Verification (OUT_W=24, FRAC_W=0 unless stated)
REQ-032 0x40490FDB (3.14159) -> out_data=3, out_inexact=1; 0x3FC00000 (1.5) -> 1 truncating, 2 with F2X_ROUND_NEAREST_EN; 0x40200000 (2.5) -> 2 both builds.
REQ-033 0x4B800000 (2^24) -> 0x7FFFFF, out_ovf=1; 0xCB000000 (-2^23) -> 0x800000, out_ovf=0; 0xFF800000 (-inf) -> 0x800000, out_ovf=1.
REQ-034 0x7FC00000 -> 0, out_nan=1; 0x00000001 -> 0, out_inexact=1; 0x80000000 -> 0, no flags.
REQ-035 FRAC_W=8: 0xBF400000 (-0.75) -> 0xFFFF40 exact; 0x3B800000 (2^-8) -> 0x000001.
REQ-036 Eight back-to-back inputs, out_ready low for cycles 2..6 -> in_ready low after pipeline fills, results in order, each held stable, none lost.
REQ-037 rst asserted while 3 operands are in flight -> out_valid=0 next cycle; no pre-reset result ever emitted.
